// File: rtl/axis_output_pipe_if.sv
// axis_output_pipe_if
//   One AXI-Stream channel: valid/ready handshake with last, data and keep.
//   DATA_W : tdata width in bits
//   KEEP_W : tkeep width (one bit per word)
//   master : drives tvalid/tlast/tdata/tkeep, receives tready
//   slave  : receives tvalid/tlast/tdata/tkeep, drives tready
interface axis_output_pipe_if #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;

  modport master (output tvalid, output tlast, output tdata, output tkeep, input tready);
  modport slave  (input tvalid, input tlast, input tdata, input tkeep, output tready);
endinterface

// File: rtl/axis_output_pipe.sv
// axis_output_pipe
//   Width converter from the wide conv-engine result stream to the narrow
//   DMA stream. One wide beat is held in a register buffer and emitted as
//   RATIO = IN_WORDS/OUT_WORDS narrow slices, lowest words first.
//   aclk         : clock, all logic on the rising edge
//   areset       : synchronous active-high reset
//   s_axis       : wide input stream  (WORD_WIDTH*IN_WORDS data, IN_WORDS keep)
//   m_axis       : narrow output stream (WORD_WIDTH*OUT_WORDS data, OUT_WORDS keep)
//   debug_config : {packet_count[15:0], beat_count[15:0]} of output handshakes
module axis_output_pipe #(
  parameter int WORD_WIDTH = 8,
  parameter int IN_WORDS   = 16,
  parameter int OUT_WORDS  = 4
) (
  input  logic                aclk,
  input  logic                areset,
  axis_output_pipe_if.slave   s_axis,
  axis_output_pipe_if.master  m_axis,
  output logic [31:0]         debug_config
);

  localparam int RATIO    = IN_WORDS / OUT_WORDS;
  localparam int CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int IN_BITS  = WORD_WIDTH * IN_WORDS;
  localparam int OUT_BITS = WORD_WIDTH * OUT_WORDS;
  localparam logic [CW-1:0] LAST_SLICE = CW'(RATIO - 1);

  logic [IN_BITS-1:0]   data_q, data_d;
  logic [IN_WORDS-1:0]  keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 full_q, full_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;

  logic [OUT_BITS-1:0]  slice_data_s;
  logic [OUT_WORDS-1:0] slice_keep_s;
  logic                 last_slice_s;
  logic                 m_last_s;
  logic                 out_hs_s;
  logic                 in_hs_s;
  logic                 s_ready_s;

  // Slice mux and handshake decode; output side depends only on registers.
  always_comb begin
    slice_data_s = data_q[int'(cnt_q) * OUT_BITS +: OUT_BITS];
    slice_keep_s = keep_q[int'(cnt_q) * OUT_WORDS +: OUT_WORDS];
    last_slice_s = (cnt_q == LAST_SLICE);
    m_last_s     = full_q && last_slice_s && last_q;
    out_hs_s     = full_q && m_axis.tready;
    // Accepting on the final slice handshake lets wide beats stream without a bubble.
    s_ready_s    = !full_q || (out_hs_s && last_slice_s);
    in_hs_s      = s_axis.tvalid && s_ready_s;
  end

  // Next-state for buffer, slice counter and debug counters.
  always_comb begin
    data_d     = data_q;
    keep_d     = keep_q;
    last_d     = last_q;
    full_d     = full_q;
    cnt_d      = cnt_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;

    if (in_hs_s) begin
      // A load always wins: either the buffer was empty or its last slice leaves now.
      data_d = s_axis.tdata;
      keep_d = s_axis.tkeep;
      last_d = s_axis.tlast;
      full_d = 1'b1;
      cnt_d  = {CW{1'b0}};
    end else if (out_hs_s) begin
      if (last_slice_s) begin
        full_d = 1'b0;
        cnt_d  = {CW{1'b0}};
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end else begin
      full_d = full_q;
    end

    if (out_hs_s) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
      if (m_last_s) begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
      end else begin
        pkt_cnt_d = pkt_cnt_q;
      end
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      data_q     <= '0;
      keep_q     <= '0;
      last_q     <= 1'b0;
      full_q     <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      beat_cnt_q <= 16'd0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      data_q     <= data_d;
      keep_q     <= keep_d;
      last_q     <= last_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign s_axis.tready = s_ready_s;
  assign m_axis.tvalid = full_q;
  assign m_axis.tdata  = slice_data_s;
  assign m_axis.tkeep  = slice_keep_s;
  assign m_axis.tlast  = m_last_s;
  assign debug_config  = {pkt_cnt_q, beat_cnt_q};

endmodule

// File: tb/tb_axis_output_pipe.sv
// tb_axis_output_pipe
//   Self-checking bench for axis_output_pipe with default parameters
//   (8-bit words, 16 in, 4 out). A queue of expected narrow slices models
//   the block: every accepted wide beat becomes four slices, each output
//   handshake retires the oldest one.
module tb_axis_output_pipe;

  localparam int W     = 8;
  localparam int IW    = 16;
  localparam int OW    = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } slice_t;

  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] dbg;

  axis_output_pipe_if #(.DATA_W(W*IW), .KEEP_W(IW)) s_if ();
  axis_output_pipe_if #(.DATA_W(W*OW), .KEEP_W(OW)) m_if ();

  axis_output_pipe #(.WORD_WIDTH(W), .IN_WORDS(IW), .OUT_WORDS(OW)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .debug_config (dbg)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  slice_t      exp_q[$];
  logic [15:0] m_beats;
  logic [15:0] m_pkts;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Model: the block accepts a wide beat only when nothing is pending, or the
  // single remaining slice is leaving in the same cycle.
  function automatic bit model_ready(input bit mr);
    return (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
  endfunction

  task automatic model_update(input bit in_hs, input bit out_hs,
                              input logic [127:0] d, input logic [15:0] k, input logic l);
    slice_t s;
    if (out_hs) begin
      s = exp_q.pop_front();
      m_beats = m_beats + 16'd1;
      if (s.l) m_pkts = m_pkts + 16'd1;
    end
    if (in_hs) begin
      for (int i = 0; i < 4; i++) begin
        s.d = d[i*32 +: 32];
        s.k = k[i*4 +: 4];
        s.l = (i == 3) && l;
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic do_reset();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    m_if.tready = 1'b0;
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    exp_q.delete();
    m_beats = 16'd0;
    m_pkts  = 16'd0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_if.tvalid); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", m_if.tlast); end
    checks++; if (m_if.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_if.tdata); end
    checks++; if (m_if.tkeep !== 4'h0) begin errors++; $display("FAIL reset_tkeep: got %h expected 0", m_if.tkeep); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", s_if.tready); end
    checks++; if (dbg !== 32'h0) begin errors++; $display("FAIL reset_debug: got %h expected 0", dbg); end
    step();
  endtask

  task automatic test_single_beat();
    logic [127:0] d;
    logic [31:0]  exp_w [4];
    exp_w = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
    do_reset();
    s_if.tdata = d; s_if.tkeep = 16'hFFFF; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL single_tready: got %b expected 1", s_if.tready); end
    step();
    s_if.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid%0d: got %b expected 1", k, m_if.tvalid); end
      checks++; if (m_if.tdata !== exp_w[k]) begin errors++; $display("FAIL single_tdata%0d: got %h expected %h", k, m_if.tdata, exp_w[k]); end
      checks++; if (m_if.tlast !== (k == 3)) begin errors++; $display("FAIL single_tlast%0d: got %b expected %b", k, m_if.tlast, (k == 3)); end
      step();
    end
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", m_if.tvalid); end
    checks++; if (dbg !== 32'h0001_0004) begin errors++; $display("FAIL single_debug: got %h expected 00010004", dbg); end
  endtask

  task automatic test_keep_mapping();
    logic [3:0] exp_k [4];
    exp_k = '{4'hF, 4'h3, 4'hF, 4'h0};
    do_reset();
    s_if.tdata = {$urandom, $urandom, $urandom, $urandom};
    s_if.tkeep = 16'h0F3F; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL keep_tvalid%0d: got %b expected 1", k, m_if.tvalid); end
      checks++; if (m_if.tkeep !== exp_k[k]) begin errors++; $display("FAIL keep_tkeep%0d: got %h expected %h", k, m_if.tkeep, exp_k[k]); end
      checks++; if (m_if.tlast !== (k == 3)) begin errors++; $display("FAIL keep_tlast%0d: got %b expected %b", k, m_if.tlast, (k == 3)); end
      step();
    end
    #1;
    checks++; if (dbg !== 32'h0001_0004) begin errors++; $display("FAIL keep_debug: got %h expected 00010004", dbg); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] bd [3];
    logic         bl [3];
    int           b;
    int           npk;
    int           sl;
    int           cur;
    npk = 0;
    for (int i = 0; i < 3; i++) begin
      bd[i] = {$urandom, $urandom, $urandom, $urandom};
      bl[i] = (i == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (bl[i]) npk++;
    end
    do_reset();
    m_if.tready = 1'b1;
    s_if.tkeep = 16'hFFFF;
    s_if.tdata = bd[0]; s_if.tlast = bl[0]; s_if.tvalid = 1'b1;
    #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b expected 1", s_if.tready); end
    step();
    b = 1;
    s_if.tdata = bd[1]; s_if.tlast = bl[1];
    for (int j = 0; j < 12; j++) begin
      sl  = j % 4;
      cur = j / 4;
      #1;
      checks++; if (m_if.tvalid !== 1'b1) begin errors++; $display("FAIL b2b_tvalid%0d: got %b expected 1", j, m_if.tvalid); end
      checks++; if (m_if.tdata !== bd[cur][sl*32 +: 32]) begin errors++; $display("FAIL b2b_tdata%0d: got %h expected %h", j, m_if.tdata, bd[cur][sl*32 +: 32]); end
      checks++; if (m_if.tlast !== (sl == 3 && bl[cur])) begin errors++; $display("FAIL b2b_tlast%0d: got %b expected %b", j, m_if.tlast, (sl == 3 && bl[cur])); end
      checks++; if (s_if.tready !== (sl == 3)) begin errors++; $display("FAIL b2b_tready%0d: got %b expected %b", j, s_if.tready, (sl == 3)); end
      step();
      if (s_if.tvalid && sl == 3) begin
        b++;
        if (b < 3) begin
          s_if.tdata = bd[b]; s_if.tlast = bl[b];
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
    end
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", m_if.tvalid); end
    checks++; if (dbg !== {16'(npk), 16'd12}) begin errors++; $display("FAIL b2b_debug: got %h expected %h", dbg, {16'(npk), 16'd12}); end
  endtask

  task automatic test_backpressure_random();
    bit rdy;
    bit in_hs;
    bit out_hs;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!s_if.tvalid && $urandom_range(0, 9) < 7) begin
        s_if.tdata  = {$urandom, $urandom, $urandom, $urandom};
        s_if.tkeep  = 16'($urandom);
        s_if.tlast  = 1'($urandom_range(0, 1));
        s_if.tvalid = 1'b1;
      end
      m_if.tready = (cyc < 240) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      rdy = model_ready(m_if.tready);
      checks++; if (m_if.tvalid !== (exp_q.size() > 0)) begin errors++; $display("FAIL bp_tvalid@%0d: got %b expected %b", cyc, m_if.tvalid, (exp_q.size() > 0)); end
      if (exp_q.size() > 0) begin
        checks++;
        if ({m_if.tdata, m_if.tkeep, m_if.tlast} !== exp_q[0]) begin
          errors++;
          $display("FAIL bp_slice@%0d: got %h/%h/%b expected %h/%h/%b", cyc, m_if.tdata, m_if.tkeep, m_if.tlast, exp_q[0].d, exp_q[0].k, exp_q[0].l);
        end
      end
      checks++; if (s_if.tready !== rdy) begin errors++; $display("FAIL bp_tready@%0d: got %b expected %b", cyc, s_if.tready, rdy); end
      checks++; if (dbg !== {m_pkts, m_beats}) begin errors++; $display("FAIL bp_debug@%0d: got %h expected %h", cyc, dbg, {m_pkts, m_beats}); end
      in_hs  = s_if.tvalid && rdy;
      out_hs = (exp_q.size() > 0) && m_if.tready;
      model_update(in_hs, out_hs, s_if.tdata, s_if.tkeep, s_if.tlast);
      step();
      if (in_hs) s_if.tvalid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_beat();
    logic [127:0] d2;
    do_reset();
    s_if.tdata = {$urandom, $urandom, $urandom, $urandom};
    s_if.tkeep = 16'hFFFF; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    step();
    step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b expected 0", m_if.tvalid); end
    checks++; if (dbg !== 32'h0) begin errors++; $display("FAIL midrst_debug: got %h expected 0", dbg); end
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL midrst_tready: got %b expected 1", s_if.tready); end
    step();
    d2 = {$urandom, $urandom, $urandom, $urandom};
    s_if.tdata = d2; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    #1;
    checks++; if (m_if.tdata !== d2[31:0]) begin errors++; $display("FAIL midrst_slice0: got %h expected %h", m_if.tdata, d2[31:0]); end
    checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL midrst_tlast: got %b expected 0", m_if.tlast); end
    exp_q.delete();
  endtask

  task automatic test_counter_wrap();
    int iter;
    bit in_hs;
    bit out_hs;
    do_reset();
    m_if.tready = 1'b1;
    s_if.tkeep  = 16'hFFFF; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    s_if.tdata  = {$urandom, $urandom, $urandom, $urandom};
    iter = 0;
    while (m_beats != 16'hFFFF && iter < 70000) begin
      in_hs  = s_if.tvalid && model_ready(1'b1);
      out_hs = exp_q.size() > 0;
      model_update(in_hs, out_hs, s_if.tdata, s_if.tkeep, s_if.tlast);
      step();
      iter++;
    end
    #1;
    checks++; if (iter >= 70000) begin errors++; $display("FAIL wrap_timeout: got %0d cycles expected under 70000", iter); end
    checks++; if (dbg !== {m_pkts, 16'hFFFF}) begin errors++; $display("FAIL wrap_ffff: got %h expected %h", dbg, {m_pkts, 16'hFFFF}); end
    in_hs  = s_if.tvalid && model_ready(1'b1);
    out_hs = exp_q.size() > 0;
    model_update(in_hs, out_hs, s_if.tdata, s_if.tkeep, s_if.tlast);
    step();
    #1;
    checks++; if (dbg[15:0] !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", dbg[15:0]); end
    checks++; if (dbg[31:16] !== m_pkts) begin errors++; $display("FAIL wrap_pkts: got %h expected %h", dbg[31:16], m_pkts); end
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    m_beats = 16'd0;
    m_pkts  = 16'd0;
    test_reset();
    test_single_beat();
    test_keep_mapping();
    test_back_to_back();
    test_backpressure_random();
    test_reset_mid_beat();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_output_pipe.md
AXIS_OUTPUT_PIPE -- requirements
Module: axis_output_pipe

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, bits per word.
REQ-002 SHALL have parameter IN_WORDS, default 16, words per conv-engine output beat (COPIES*GROUPS*MEMBERS flattened).
REQ-003 SHALL have parameter OUT_WORDS, default 4, words per output beat; IN_WORDS SHALL be an integer multiple of OUT_WORDS; RATIO = IN_WORDS/OUT_WORDS.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tlast (input, 1), s_axis_tdata (input, WORD_WIDTH*IN_WORDS), s_axis_tkeep (input, IN_WORDS): wide conv-engine result stream.
REQ-007 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1), m_axis_tdata (output, WORD_WIDTH*OUT_WORDS), m_axis_tkeep (output, OUT_WORDS): narrow DMA-side stream.
REQ-008 SHALL have port debug_config, output, 32: {packet_count[15:0], beat_count[15:0]}.

Function
REQ-009 SHALL hold one wide beat in a register buffer (data, keep, last) with a full flag; no other storage.
REQ-010 SHALL keep a slice counter 0..RATIO-1 selecting output slice k = buffer words [k*OUT_WORDS +: OUT_WORDS], word 0 = LSB, slice 0 emitted first.
REQ-011 SHALL drive m_axis_tvalid = full; m_axis_tdata/m_axis_tkeep = selected slice of buffer (mux from registers, no combinational path from s_axis_*).
REQ-012 SHALL drive m_axis_tlast = 1 only when counter = RATIO-1 and buffered last = 1.
REQ-013 SHALL drive s_axis_tready = !full || (m_axis_tvalid && m_axis_tready && counter = RATIO-1), allowing back-to-back wide beats without a bubble.
REQ-014 On s_axis_tvalid && s_axis_tready: load buffer, set full, counter <= 0; first slice valid the next cycle (latency 1 cycle).
REQ-015 On output handshake with counter < RATIO-1: counter increments, buffer unchanged.
REQ-016 On output handshake with counter = RATIO-1 and no simultaneous input handshake: full <= 0, counter <= 0.
REQ-017 Simultaneous final-slice output handshake and input handshake: buffer reloads, full stays 1, counter <= 0; no slice lost or duplicated.
REQ-018 With m_axis_tready = 0, tdata/tkeep/tlast/tvalid SHALL remain stable until handshake.
REQ-019 Slices with all-zero tkeep SHALL still be emitted (no suppression).
REQ-020 beat_count SHALL increment on every output handshake; packet_count on every output handshake with m_axis_tlast = 1; both wrap 0xFFFF -> 0.

Reset
REQ-021 While areset = 1 at a rising edge: full <= 0, counter <= 0, buffer <= 0, beat_count <= 0, packet_count <= 0.
REQ-022 Outputs after reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0, s_axis_tready = 1, debug_config = 0.
REQ-023 Reset mid-operation SHALL discard buffered beat and remaining slices; first cycle after reset deassertion behaves as REQ-022.

Verification
REQ-024 Single beat: data words 0x00..0x0F, keep 0xFFFF, last 1, m_ready 1 -> 4 output beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, tlast only on 4th, packet_count 1, beat_count 4.
REQ-025 Back-to-back: 3 wide beats, s_valid and m_ready held 1 -> 12 consecutive output beats with m_axis_tvalid never dropping, s_axis_tready high on cycles of slice 3.
REQ-026 Backpressure: m_ready toggled 1,0,0,1,... -> output values stable while stalled; s_axis_tready = 0 until final slice handshake; no data lost.
REQ-027 Keep mapping: s_axis_tkeep 0x0F3F, last 1 -> m_axis_tkeep 0xF, 0x3, 0xF, 0x0 in order; 0x0 slice emitted with tlast = 1.
REQ-028 Reset mid-beat: areset asserted after slice 1 handshake -> next cycle m_axis_tvalid 0, debug_config 0, s_axis_tready 1; new beat afterward starts at slice 0.
REQ-029 Counter wrap: 65536 single-slice-last packets (force beat_count to 0xFFFF) -> beat_count rolls to 0x0000 on next handshake.
